// File: rtl/audio_out_pkg.sv
// ============================================================================
// Module      : audio_out_pkg
// Description : Shared widths, mid-scale duty and output mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_out_pkg;

  localparam int SAMPLE_BITS = 8;
  localparam int PWM_BITS    = 8;

  localparam logic [PWM_BITS-1:0] MIDSCALE = 8'h80;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_SD  = 1'b1
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/audio_pwm_out_if.sv
// ============================================================================
// Module      : audio_pwm_out_if
// Description : Sample hand-off bundle between the oscillator and the modulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface audio_pwm_out_if #(
  parameter int SAMPLE_BITS = audio_out_pkg::SAMPLE_BITS
);

  logic [SAMPLE_BITS-1:0] sample_in;
  logic                   sample_valid;
  logic                   clear_overrun;
  logic                   sample_taken;
  logic                   overrun;

  modport master (
    output sample_in,
    output sample_valid,
    output clear_overrun,
    input  sample_taken,
    input  overrun
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  clear_overrun,
    output sample_taken,
    output overrun
  );

endinterface

`default_nettype wire

// File: rtl/audio_pwm_out_sd.sv
// ============================================================================
// Module      : sd_modulator
// Description : First-order sigma-delta accumulator; carry is the 1-bit stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_modulator #(
  parameter int PWM_BITS = audio_out_pkg::PWM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty,
  output logic                carry
);

  logic [PWM_BITS:0] acc;

  // Carry is dropped back to zero each step so it is a pure overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (enable) begin
      acc <= {1'b0, acc[PWM_BITS-1:0]} + {1'b0, duty};
    end
  end

  assign carry = acc[PWM_BITS];

endmodule

`default_nettype wire

// File: rtl/audio_pwm_out.sv
// ============================================================================
// Module      : audio_pwm_out
// Description : Signed sample to 1-bit audio via frame PWM, double-buffered duty.
//               Optional sigma-delta mode when SIGMA_DELTA_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_pwm_out #(
  parameter int SAMPLE_BITS = audio_out_pkg::SAMPLE_BITS,
  parameter int PWM_BITS    = audio_out_pkg::PWM_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  audio_pwm_out_if.slave        smp,
  output logic                  pwm_out,
  output logic                  frame_start
);

  localparam logic [PWM_BITS-1:0] CNT_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] MID_DUTY = {1'b1, {(PWM_BITS-1){1'b0}}};

  logic [PWM_BITS-1:0]    cnt;
  logic [PWM_BITS-1:0]    active;
  logic [PWM_BITS-1:0]    pending;
  logic                   pending_full;
  logic                   overrun_q;
  logic                   taken_q;

  logic [SAMPLE_BITS-1:0] conv;
  logic                   wrap;
  logic                   sd_sel;
  logic                   xfer_slot;
  logic                   do_xfer;
  logic                   ovr_event;
  logic                   mod_bit;

  // Two's complement to offset binary: flip the sign bit.
  assign conv = {~smp.sample_in[SAMPLE_BITS-1], smp.sample_in[SAMPLE_BITS-2:0]};

  assign wrap      = enable && (cnt == CNT_MAX);
  assign xfer_slot = sd_sel ? enable : wrap;
  assign do_xfer   = xfer_slot && pending_full;
  assign ovr_event = smp.sample_valid && pending_full && !do_xfer && !sd_sel;

`ifdef SIGMA_DELTA_EN
  audio_out_pkg::mode_e mode_q;
  logic                 sd_carry;

  // Mode only changes on a frame boundary so a frame is never split.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= audio_out_pkg::MODE_PWM;
    end else if (wrap) begin
      mode_q <= audio_out_pkg::mode_e'(mode);
    end
  end

  assign sd_sel = (mode_q == audio_out_pkg::MODE_SD);

  sd_modulator #(
    .PWM_BITS (PWM_BITS)
  ) u_sd_modulator (
    .clk    (clk),
    .reset  (reset),
    .enable (enable && sd_sel),
    .duty   (active),
    .carry  (sd_carry)
  );

  assign mod_bit = sd_sel ? sd_carry : (cnt < active);
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign sd_sel      = 1'b0;
  assign mod_bit     = (cnt < active);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      active       <= MID_DUTY;
      pending      <= MID_DUTY;
      pending_full <= 1'b0;
      overrun_q    <= 1'b0;
      pwm_out      <= 1'b0;
      frame_start  <= 1'b0;
      taken_q      <= 1'b0;
    end else begin
      if (enable) begin
        cnt <= cnt + 1'b1;
      end

      if (do_xfer) begin
        active <= pending;
      end

      // A new sample always lands in pending; a coincident transfer has
      // already consumed the old value above, so pending stays full.
      if (smp.sample_valid) begin
        pending      <= PWM_BITS'(conv);
        pending_full <= 1'b1;
      end else if (do_xfer) begin
        pending_full <= 1'b0;
      end

      if (ovr_event) begin
        overrun_q <= 1'b1;
      end else if (smp.clear_overrun) begin
        overrun_q <= 1'b0;
      end

      pwm_out     <= enable && mod_bit;
      frame_start <= wrap;
      taken_q     <= do_xfer;
    end
  end

  assign smp.sample_taken = taken_q;
  assign smp.overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_pwm_out.sv
// ============================================================================
// Module      : tb_audio_pwm_out
// Description : Directed, table-driven bench for audio_pwm_out (SIGMA_DELTA_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_audio_pwm_out;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic mode;
  logic pwm_out;
  logic frame_start;

  audio_pwm_out_if #(.SAMPLE_BITS(8)) smp();

  audio_pwm_out #(
    .SAMPLE_BITS (8),
    .PWM_BITS    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .smp         (smp),
    .pwm_out     (pwm_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] sample;
    int         exp_high;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input string name);
    int k = 0;
    while (frame_start !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    check(name, int'(frame_start), 1);
  endtask

  // Starts on a frame_start cycle; observes 256 output cycles, optionally
  // strobing up to two samples at given offsets, and ends on the next one.
  task automatic measure_frame(input int s1_at, input logic [7:0] s1_val,
                               input int s2_at, input logic [7:0] s2_val,
                               output int highs, output int taken, output int next_fs);
    highs = 0;
    taken = 0;
    for (int i = 0; i < 256; i++) begin
      highs += int'(pwm_out);
      taken += int'(smp.sample_taken);
      if (i == s1_at) begin
        smp.sample_in    = s1_val;
        smp.sample_valid = 1'b1;
      end else if (i == s2_at) begin
        smp.sample_in    = s2_val;
        smp.sample_valid = 1'b1;
      end else begin
        smp.sample_valid = 1'b0;
      end
      tick();
    end
    smp.sample_valid = 1'b0;
    next_fs = int'(frame_start);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs, taken, fs, prev, dis_high, dis_fs, fs_cnt;

    vecs[0] = '{8'h7F, 255};
    vecs[1] = '{8'h80, 0};
    vecs[2] = '{8'h00, 128};
    vecs[3] = '{8'h10, 144};
    vecs[4] = '{8'hF0, 112};
    vecs[5] = '{8'h81, 1};

    reset             = 1'b1;
    enable            = 1'b0;
    mode              = 1'b0;
    smp.sample_in     = '0;
    smp.sample_valid  = 1'b0;
    smp.clear_overrun = 1'b0;
    repeat (3) tick();

    check("reset pwm_out", int'(pwm_out), 0);
    check("reset frame_start", int'(frame_start), 0);
    check("reset sample_taken", int'(smp.sample_taken), 0);
    check("reset overrun", int'(smp.overrun), 0);

    reset  = 1'b0;
    enable = 1'b1;
    wait_frame("first frame_start");
    for (int f = 0; f < 2; f++) begin
      measure_frame(-1, 8'h00, -1, 8'h00, highs, taken, fs);
      check($sformatf("idle%0d duty", f), highs, 128);
      check($sformatf("idle%0d period", f), fs, 1);
      check($sformatf("idle%0d taken", f), taken, 0);
    end

    prev = 128;
    for (int v = 0; v < 6; v++) begin
      measure_frame(100, vecs[v].sample, -1, 8'h00, highs, taken, fs);
      check($sformatf("vec%0d hold duty", v), highs, prev);
      check($sformatf("vec%0d hold taken", v), taken, 0);
      measure_frame(-1, 8'h00, -1, 8'h00, highs, taken, fs);
      check($sformatf("vec%0d new duty", v), highs, vecs[v].exp_high);
      check($sformatf("vec%0d taken", v), taken, 1);
      check($sformatf("vec%0d period", v), fs, 1);
      prev = vecs[v].exp_high;
    end

    // Two strobes in one frame: latest (0x20 -> 0xA0) wins and overrun sticks.
    measure_frame(50, 8'h10, 60, 8'h20, highs, taken, fs);
    check("ovr hold duty", highs, 1);
    check("ovr flag set", int'(smp.overrun), 1);
    measure_frame(-1, 8'h00, -1, 8'h00, highs, taken, fs);
    check("ovr new duty", highs, 160);
    check("ovr taken", taken, 1);
    check("ovr sticky", int'(smp.overrun), 1);
    smp.clear_overrun = 1'b1;
    tick();
    smp.clear_overrun = 1'b0;
    check("ovr cleared", int'(smp.overrun), 0);

    // Strobe on the wrap cycle: 0xB0 transfers, 0xD0 waits a frame, no overrun.
    wait_frame("coinc align");
    measure_frame(50, 8'h30, 255, 8'h50, highs, taken, fs);
    check("coinc hold duty", highs, 160);
    check("coinc no overrun", int'(smp.overrun), 0);
    measure_frame(-1, 8'h00, -1, 8'h00, highs, taken, fs);
    check("coinc old pending duty", highs, 176);
    check("coinc taken1", taken, 1);
    measure_frame(-1, 8'h00, -1, 8'h00, highs, taken, fs);
    check("coinc new pending duty", highs, 208);
    check("coinc taken2", taken, 1);
    check("coinc overrun still 0", int'(smp.overrun), 0);

    // Enable low for 50 cycles at cnt 100 with duty 208.
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      highs += int'(pwm_out);
      tick();
    end
    enable   = 1'b0;
    dis_high = 0;
    dis_fs   = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      dis_high += int'(pwm_out);
      dis_fs   += int'(frame_start);
    end
    check("disabled pwm high count", dis_high, 0);
    check("disabled frame_start count", dis_fs, 0);
    enable = 1'b1;
    fs_cnt = 0;
    for (int j = 0; j < 156; j++) begin
      tick();
      highs  += int'(pwm_out);
      fs_cnt += int'(frame_start);
    end
    check("resume frame_start at cnt 255", int'(frame_start), 1);
    check("resume single frame_start", fs_cnt, 1);
    check("paused frame duty", highs, 207);

    // clear_overrun loses to a coincident overrun event.
    smp.sample_in    = 8'h7F;
    smp.sample_valid = 1'b1;
    tick();
    smp.clear_overrun = 1'b1;
    tick();
    smp.sample_valid  = 1'b0;
    smp.clear_overrun = 1'b0;
    check("ovr beats clear", int'(smp.overrun), 1);

    // Mid-frame reset with a pending sample and a coincident strobe.
    repeat (30) tick();
    reset            = 1'b1;
    smp.sample_valid = 1'b1;
    tick();
    check("midreset pwm_out", int'(pwm_out), 0);
    check("midreset frame_start", int'(frame_start), 0);
    check("midreset sample_taken", int'(smp.sample_taken), 0);
    check("midreset overrun", int'(smp.overrun), 0);
    reset            = 1'b0;
    smp.sample_valid = 1'b0;
    wait_frame("post-reset frame_start");
    measure_frame(-1, 8'h00, -1, 8'h00, highs, taken, fs);
    check("post-reset duty", highs, 128);
    check("post-reset taken", taken, 0);

`ifdef SIGMA_DELTA_EN
    mode = 1'b1;
    measure_frame(-1, 8'h00, -1, 8'h00, highs, taken, fs);
    check("sd switch frame still pwm", highs, 128);
    smp.sample_in    = 8'h40;
    smp.sample_valid = 1'b1;
    tick();
    smp.sample_valid = 1'b0;
    tick();
    check("sd taken next cycle", int'(smp.sample_taken), 1);
    repeat (8) tick();
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      highs += int'(pwm_out);
    end
    check("sd 3 of 4 density", highs, 48);
    check("sd no overrun", int'(smp.overrun), 0);
`else
    mode = 1'b1;
    measure_frame(-1, 8'h00, -1, 8'h00, highs, taken, fs);
    measure_frame(-1, 8'h00, -1, 8'h00, highs, taken, fs);
    check("mode ignored duty", highs, 128);
    check("mode ignored period", fs, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
